dmem_arbiter: RTL

Two-port controller that shares the single `data_memory` (32-bit word, 6-bit word address, read/write/busywait handshake) between the CPU load/store port (port 0) and a secondary master such as a loader or DMA (port 1). It round-robin arbitrates the requesters and registers the granted command toward memory. It holds the memory strobes until the memory drops `busywait`, then returns read data and releases the winner. A timeout aborts an access that never completes.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter_rr_pick2.sv | 12 +
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Word-addressed read/write/busywait bus used by both requesters and the memory side.
interface dmem_arbiter_if #(
  parameter int N = 32,
  parameter int A = 6
);
  logic         read;
  logic         write;
  logic [A-1:0] address;
  logic [N-1:0] writedata;
  logic [N-1:0] readdata;
  logic         busywait;
  logic         error;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait, error
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait, error
  );

  // The memory itself reports no error.
  modport mem_master (
    output read, write, address, writedata,
    input  readdata, busywait
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin select: on a tie the port other than last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid  = |req;
    winner = (&req) ? ~last : req[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU port (req0) and an auxiliary master (req1),
// with round-robin arbitration, registered memory command and an access timeout.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned A       = 6,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  dmem_arbiter_if.slave      req0,
  dmem_arbiter_if.slave      req1,
  dmem_arbiter_if.mem_master mem,
  output logic               grant
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          last;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [1:0]    req_any;
  logic          pick_valid;
  logic          pick_winner;
  logic          sel_read;
  logic          sel_write;
  logic [A-1:0]  sel_addr;
  logic [N-1:0]  sel_wdata;
  logic          done;
  logic          expire;

  assign req_any = {req1.read | req1.write, req0.read | req0.write};

  rr_pick2 u_pick (
    .req    (req_any),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // A requester raising both strobes is served as a write.
  always_comb begin
    if (pick_winner == PORT_AUX) begin
      sel_write = req1.write;
      sel_read  = req1.read & ~req1.write;
      sel_addr  = req1.address;
      sel_wdata = req1.writedata;
    end else begin
      sel_write = req0.write;
      sel_read  = req0.read & ~req0.write;
      sel_addr  = req0.address;
      sel_wdata = req0.writedata;
    end
  end

  always_comb begin
    count_next = (count == CW'(TIMEOUT)) ? count : count + 1'b1;
    done       = (count != '0) && !mem.busywait;
    expire     = (count_next == CW'(TIMEOUT));
  end

  assign req0.busywait = (req0.read | req0.write) & ~((state == RELEASE) && (grant == PORT_CPU));
  assign req1.busywait = (req1.read | req1.write) & ~((state == RELEASE) && (grant == PORT_AUX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      last          <= PORT_AUX;
      count         <= '0;
      grant         <= PORT_CPU;
      mem.read      <= 1'b0;
      mem.write     <= 1'b0;
      mem.address   <= '0;
      mem.writedata <= '0;
      req0.readdata <= '0;
      req1.readdata <= '0;
      req0.error    <= 1'b0;
      req1.error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant         <= pick_winner;
            mem.read      <= sel_read;
            mem.write     <= sel_write;
            mem.address   <= sel_addr;
            mem.writedata <= sel_wdata;
            count         <= '0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          count <= count_next;
          // Completion wins over a timeout landing on the same edge.
          if (done) begin
            if (mem.read) begin
              if (grant == PORT_AUX) req1.readdata <= mem.readdata;
              else                   req0.readdata <= mem.readdata;
            end
            mem.read  <= 1'b0;
            mem.write <= 1'b0;
            last      <= grant;
            state     <= RELEASE;
          end else if (expire) begin
            if (grant == PORT_AUX) begin
              req1.readdata <= '0;
              req1.error    <= 1'b1;
            end else begin
              req0.readdata <= '0;
              req0.error    <= 1'b1;
            end
            mem.read  <= 1'b0;
            mem.write <= 1'b0;
            last      <= grant;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          req0.error <= 1'b0;
          req1.error <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
